sram_access_engine: RTL and testbench

Responder end of the shared-memory access interface: consumes the multiplexed access strobes (address, read-into-CPU-latch, read-into-PPU-latch, write, write data) and executes each access against an external asynchronous 8-bit SRAM. Read data is returned in two independent holding latches, one for the CPU and one for the PPU. Runs on the fast system clock; one access is presented per ce cycle, and each access completes before the next ce.

---
 rtl/sram_access_engine.sv | 170 +++++++++++++++++
 tb/tb_sram_access_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_engine.sv
// Purpose: executes one multiplexed access per ce slot against an async 8-bit SRAM; CPU/PPU read latches.
// Latency: accept at E0 -> read data in latch after E0+1+WAIT_STATES; pins registered, SETUP/STROBE/HOLD.
// Backpressure: none; a command arriving in SETUP/STROBE is dropped and flags sticky overrun.
module sram_access_engine #(
    parameter int ADDR_W      = 22,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic [21:0]       memory_addr,
    input  logic              memory_read_cpu,
    input  logic              memory_read_ppu,
    input  logic              memory_write,
    input  logic [7:0]        memory_din,
    output logic [7:0]        cpu_dout,
    output logic [7:0]        ppu_dout,
    output logic              cpu_valid,
    output logic              ppu_valid,
    output logic              busy,
    output logic              overrun,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;
    logic              op_rc_q, op_rc_d;
    logic              op_rp_q, op_rp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dq_q, dq_d;
    logic [7:0]        cpu_dout_q, cpu_dout_d;
    logic [7:0]        ppu_dout_q, ppu_dout_d;
    logic              cpu_valid_q, cpu_valid_d;
    logic              ppu_valid_q, ppu_valid_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;

    logic any_op, accept, drop;

    // Next-state, capture and next pin values; pins are derived from the next state so they are registered.
    always_comb begin
        any_op      = memory_write | memory_read_cpu | memory_read_ppu;
        accept      = ce && any_op && (state_q == S_IDLE || state_q == S_HOLD);
        drop        = ce && any_op && (state_q == S_SETUP || state_q == S_STROBE);

        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        op_rc_d     = op_rc_q;
        op_rp_d     = op_rp_q;
        addr_d      = addr_q;
        dq_d        = dq_q;
        cpu_dout_d  = cpu_dout_q;
        ppu_dout_d  = ppu_dout_q;
        cpu_valid_d = 1'b0;
        ppu_valid_d = 1'b0;
        overrun_d   = overrun_q | drop;

        case (state_q)
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = CNT_INIT;
            end
            S_STROBE: begin
                if (cnt_q == 4'd0) begin
                    // Last strobe cycle: data bus is stable while oe_n is still low.
                    state_d = S_HOLD;
                    if (op_rc_q) begin
                        cpu_dout_d  = sram_dq_in;
                        cpu_valid_d = 1'b1;
                    end
                    if (op_rp_q) begin
                        ppu_dout_d  = sram_dq_in;
                        ppu_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A write takes precedence; read flags then do not matter.
        if (accept) begin
            state_d = S_SETUP;
            op_wr_d = memory_write;
            op_rc_d = ~memory_write & memory_read_cpu;
            op_rp_d = ~memory_write & memory_read_ppu;
            addr_d  = memory_addr[ADDR_W-1:0];
            dq_d    = memory_din;
        end

        ce_n_d  = (state_d == S_IDLE);
        oe_n_d  = ~((state_d == S_STROBE) && !op_wr_d);
        we_n_d  = ~((state_d == S_STROBE) && op_wr_d);
        dq_oe_d = (state_d != S_IDLE) && op_wr_d;
        busy_d  = (state_d == S_SETUP) || (state_d == S_STROBE);
    end

    // State, latches and pin registers; reset releases every strobe at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            op_wr_q     <= 1'b0;
            op_rc_q     <= 1'b0;
            op_rp_q     <= 1'b0;
            addr_q      <= '0;
            dq_q        <= 8'd0;
            cpu_dout_q  <= 8'd0;
            ppu_dout_q  <= 8'd0;
            cpu_valid_q <= 1'b0;
            ppu_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            op_rc_q     <= op_rc_d;
            op_rp_q     <= op_rp_d;
            addr_q      <= addr_d;
            dq_q        <= dq_d;
            cpu_dout_q  <= cpu_dout_d;
            ppu_dout_q  <= ppu_dout_d;
            cpu_valid_q <= cpu_valid_d;
            ppu_valid_q <= ppu_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
        end
    end

    assign cpu_dout    = cpu_dout_q;
    assign ppu_dout    = ppu_dout_q;
    assign cpu_valid   = cpu_valid_q;
    assign ppu_valid   = ppu_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_access_engine.sv
// Purpose: directed bench for sram_access_engine with a behavioural async SRAM.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: exercises back-to-back slots and the dropped-command overrun path.
module tb_sram_access_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b0;
    logic [21:0] memory_addr = '0;
    logic        memory_read_cpu = 1'b0;
    logic        memory_read_ppu = 1'b0;
    logic        memory_write = 1'b0;
    logic [7:0]  memory_din = '0;
    logic [7:0]  cpu_dout, ppu_dout;
    logic        cpu_valid, ppu_valid, busy, overrun;
    logic [21:0] sram_addr;
    logic [7:0]  sram_dq_out;
    logic        sram_dq_oe;
    logic [7:0]  sram_dq_in = 8'hEE;
    logic        sram_ce_n, sram_oe_n, sram_we_n;

    int n_tests = 0;
    int n_fail  = 0;

    sram_access_engine #(.ADDR_W(22), .WAIT_STATES(2)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .memory_addr(memory_addr), .memory_read_cpu(memory_read_cpu),
        .memory_read_ppu(memory_read_ppu), .memory_write(memory_write),
        .memory_din(memory_din), .cpu_dout(cpu_dout), .ppu_dout(ppu_dout),
        .cpu_valid(cpu_valid), .ppu_valid(ppu_valid), .busy(busy), .overrun(overrun),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: write while we_n is low, read data settles by the falling edge.
    logic [7:0] mem [int];

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe)
            mem[int'(sram_addr)] = sram_dq_out;
    end

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_oe_n && mem.exists(int'(sram_addr)))
            sram_dq_in = mem[int'(sram_addr)];
        else
            sram_dq_in = 8'hEE;
    end

    // Pin activity counters, sampled mid-cycle.
    int   oe_low = 0, we_low = 0, oe_fall = 0, cv_cnt = 0, pv_cnt = 0;
    logic oe_prev = 1'b1;

    always @(negedge clk) begin
        if (!sram_oe_n) oe_low++;
        if (!sram_we_n) we_low++;
        if (oe_prev && !sram_oe_n) oe_fall++;
        oe_prev = sram_oe_n;
        if (cpu_valid) cv_cnt++;
        if (ppu_valid) pv_cnt++;
    end

    int s_oe, s_we, s_fall, s_cv, s_pv;

    task automatic snap();
        s_oe = oe_low; s_we = we_low; s_fall = oe_fall; s_cv = cv_cnt; s_pv = pv_cnt;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for exactly one ce cycle; returns just after the accepting edge.
    task automatic issue(input logic [21:0] a, input logic rc, input logic rp,
                         input logic wr, input logic [7:0] d);
        ce = 1'b1; memory_addr = a; memory_read_cpu = rc;
        memory_read_ppu = rp; memory_write = wr; memory_din = d;
        tick();
        ce = 1'b0; memory_read_cpu = 1'b0; memory_read_ppu = 1'b0; memory_write = 1'b0;
    endtask

    initial begin
        mem[32'h001234] = 8'hA5;
        mem[32'h000100] = 8'h11;
        mem[32'h000200] = 8'h22;
        mem[32'h000300] = 8'h3C;
        mem[32'h000400] = 8'h01;
        mem[32'h000500] = 8'h7E;
        mem[32'h000700] = 8'h42;

        // Reset state
        #12;
        chk("rst_ce_n", sram_ce_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_dq_out", sram_dq_out, 0);
        chk("rst_cpu_dout", cpu_dout, 0);
        chk("rst_ppu_dout", ppu_dout, 0);
        chk("rst_busy_ovr", {busy, overrun, cpu_valid, ppu_valid}, 0);
        reset_n = 1'b1;
        tick();

        // PPU read at 0x001234
        snap();
        issue(22'h001234, 0, 1, 0, 8'h00);
        chk("rd_setup_addr", sram_addr, 32'h001234);
        chk("rd_setup_ce_n", sram_ce_n, 0);
        chk("rd_setup_oe_n", sram_oe_n, 1);
        chk("rd_setup_busy", busy, 1);
        chk("rd_setup_dq_oe", sram_dq_oe, 0);
        tick();
        chk("rd_strobe1_oe_n", sram_oe_n, 0);
        chk("rd_strobe1_addr", sram_addr, 32'h001234);
        tick();
        chk("rd_strobe2_oe_n", sram_oe_n, 0);
        tick();
        chk("rd_hold_ppu_dout", ppu_dout, 8'hA5);
        chk("rd_hold_ppu_valid", ppu_valid, 1);
        chk("rd_hold_cpu_valid", cpu_valid, 0);
        chk("rd_hold_oe_n", sram_oe_n, 1);
        chk("rd_hold_ce_n", sram_ce_n, 0);
        chk("rd_hold_addr", sram_addr, 32'h001234);
        chk("rd_hold_busy", busy, 0);
        tick();
        chk("rd_idle_ppu_valid", ppu_valid, 0);
        chk("rd_idle_ce_n", sram_ce_n, 1);
        chk("rd_cpu_dout_kept", cpu_dout, 0);
        chk("rd_oe_low_cycles", oe_low - s_oe, 2);

        // Write 0x5C at the top address, then read it back into the CPU latch
        snap();
        issue(22'h3FFFFF, 0, 0, 1, 8'h5C);
        chk("wr_setup_dq_oe", sram_dq_oe, 1);
        chk("wr_setup_dq_out", sram_dq_out, 8'h5C);
        chk("wr_setup_we_n", sram_we_n, 1);
        chk("wr_setup_addr", sram_addr, 32'h3FFFFF);
        tick();
        chk("wr_strobe_we_n", sram_we_n, 0);
        chk("wr_strobe_oe_n", sram_oe_n, 1);
        tick();
        tick();
        chk("wr_hold_dq_oe", sram_dq_oe, 1);
        chk("wr_hold_we_n", sram_we_n, 1);
        tick();
        chk("wr_idle_dq_oe", sram_dq_oe, 0);
        chk("wr_we_low_cycles", we_low - s_we, 2);
        chk("wr_no_valids", (cv_cnt - s_cv) + (pv_cnt - s_pv), 0);
        chk("wr_mem", mem[32'h3FFFFF], 8'h5C);
        chk("wr_ppu_untouched", ppu_dout, 8'hA5);
        issue(22'h3FFFFF, 1, 0, 0, 8'h00);
        repeat (3) tick();
        chk("rb_cpu_dout", cpu_dout, 8'h5C);
        chk("rb_cpu_valid", cpu_valid, 1);
        tick();

        // Back-to-back at minimum spacing (4 clk)
        issue(22'h000100, 1, 0, 0, 8'h00);
        repeat (3) tick();
        chk("b2b_hold_cpu_dout", cpu_dout, 8'h11);
        chk("b2b_hold_cpu_valid", cpu_valid, 1);
        issue(22'h000200, 0, 1, 0, 8'h00);
        chk("b2b_setup_busy", busy, 1);
        chk("b2b_setup_ce_n", sram_ce_n, 0);
        chk("b2b_setup_addr", sram_addr, 32'h000200);
        repeat (3) tick();
        chk("b2b_ppu_dout", ppu_dout, 8'h22);
        chk("b2b_ppu_valid", ppu_valid, 1);
        chk("b2b_cpu_dout_kept", cpu_dout, 8'h11);
        chk("b2b_overrun", overrun, 0);
        tick();

        // Overrun: write arrives during STROBE of a read
        snap();
        issue(22'h000300, 1, 0, 0, 8'h00);
        tick();
        issue(22'h000400, 0, 0, 1, 8'h99);
        chk("ovr_flag", overrun, 1);
        chk("ovr_we_n", sram_we_n, 1);
        chk("ovr_addr", sram_addr, 32'h000300);
        tick();
        chk("ovr_cpu_dout", cpu_dout, 8'h3C);
        chk("ovr_cpu_valid", cpu_valid, 1);
        repeat (2) tick();
        chk("ovr_no_we", we_low - s_we, 0);
        chk("ovr_mem_kept", mem[32'h000400], 8'h01);
        chk("ovr_sticky", overrun, 1);

        // Dual read: one SRAM read loads both latches
        snap();
        issue(22'h000500, 1, 1, 0, 8'h00);
        repeat (3) tick();
        chk("dual_cpu_dout", cpu_dout, 8'h7E);
        chk("dual_ppu_dout", ppu_dout, 8'h7E);
        chk("dual_valids", {cpu_valid, ppu_valid}, 2'b11);
        tick();
        chk("dual_oe_pulses", oe_fall - s_fall, 1);
        chk("dual_oe_low", oe_low - s_oe, 2);
        chk("dual_ovr_sticky", overrun, 1);

        // Reset in the middle of a write strobe
        issue(22'h000600, 0, 0, 1, 8'hAB);
        tick();
        chk("rmid_we_n_before", sram_we_n, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("rmid_we_n", sram_we_n, 1);
        chk("rmid_dq_oe", sram_dq_oe, 0);
        chk("rmid_ce_n", sram_ce_n, 1);
        chk("rmid_overrun", overrun, 0);
        chk("rmid_latches", {cpu_dout, ppu_dout}, 16'h0000);
        #1 reset_n = 1'b1;
        tick();
        chk("rmid_idle_busy", busy, 0);
        issue(22'h000700, 0, 1, 0, 8'h00);
        chk("rmid_next_setup", busy, 1);
        repeat (3) tick();
        chk("rmid_next_ppu", ppu_dout, 8'h42);
        chk("rmid_next_valid", ppu_valid, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
